fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end. It replaces the single-PC, stall-driven fetch with a decoupled request/response pipeline and an instruction queue. It issues word requests to a synchronous 1-cycle-latency instruction memory and buffers returned instructions with their PC and PC+4. Decode consumes entries through a valid/ready handshake. Redirects from execute flush the queue and discard any in-flight response.

Parameters:
QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset
IMEM_AW, 12, word-address width presented to instruction memory

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
redirect  input  1  taken branch/jump from execute; flush and refetch
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
imem_en  output  1  memory read request this cycle
imem_addr  output  IMEM_AW  word address, equal to fetch_pc[IMEM_AW+1:2]
imem_rdata  input  32  read data, valid in the cycle after imem_en
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head
out_pc  output  32  PC of head instruction
out_pcplus4  output  32  out_pc + 4, modulo 2^32
out_instr  output  32  head instruction word

Behaviour:
- Reset (rst=1 at a clock edge):
  - fetch_pc <= RESET_PC; queue emptied; in-flight valid cleared.
  - out_valid=0, imem_en=0. out_pc, out_pcplus4 and out_instr read 0.
- Request rule: imem_en=1 when rst=0, redirect=0 and (queue_count + inflight) < QUEUE_DEPTH.
  - On a request, fetch_pc <= fetch_pc + 4 (32-bit wrap).
  - The request's PC is latched in inflight_pc; inflight <= 1.
- Response: in the cycle after a request, if inflight=1 and no redirect, {inflight_pc, inflight_pc+4, imem_rdata} is written at the queue tail.
  - The entry is visible at the head the following cycle. The queue is registered with no fall-through.
- Latency:
  - rst released at cycle 0: request in cycle 0, data in cycle 1, out_valid=1 in cycle 2 with out_pc=RESET_PC.
  - Redirect at cycle t: request in t+1, data in t+2, out_valid in t+3.
- Steady state: with out_ready held high, one instruction per cycle with sequential PCs.
- Handshake:
  - Pop when out_valid && out_ready.
  - Head outputs stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop, except on redirect or rst.
- Full: no request is issued when queue_count + inflight = QUEUE_DEPTH. An accepted response therefore never overflows.
- Simultaneous pop and enqueue: count unchanged, both pointers advance. Pointers wrap modulo QUEUE_DEPTH.
- Redirect, all in the same edge:
  - Queue flushed (count=0).
  - In-flight response dropped (inflight <= 0).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - A concurrent pop or enqueue is discarded; redirect wins.
- Redirect in consecutive cycles: the last one wins. No stale data ever reaches the outputs.
- rst and redirect both high: rst wins.
- Sticky-free design: no state survives a redirect except fetch_pc.

Optional Feature:
FETCH_PERF_EN. When defined, adds two outputs:
- perf_fetched (32): increments on every pop.
- perf_flushes (32): increments on every redirect cycle.
Both reset to 0 on rst and wrap at 2^32. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_PC=0x100, imem returns addr-tagged data, out_ready=1:
  - out_valid rises 2 cycles after rst falls.
  - out_pc sequence 0x100, 0x104, 0x108…; out_pcplus4 = out_pc + 4.
- out_ready=0 for 10 cycles, QUEUE_DEPTH=4:
  - Exactly 4 entries fill (0x100–0x10C); imem_en then stays 0.
  - Head holds 0x100 stable.
  - Releasing out_ready drains in order, and requests resume at 0x110.
- Redirect to 0x2002 while the queue is full and a response is in flight:
  - Next cycle out_valid=0.
  - First new out_pc = 0x2000 exactly 3 cycles after redirect.
  - No entry from 0x110 or later ever appears.
- redirect asserted in the same cycle as a pop and an enqueue: count becomes 0, and the popped entry is counted once by the consumer.
- fetch_pc near 0xFFFF_FFF8, out_ready=1: PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. out_pcplus4 of 0xFFFF_FFFC is 0x0000_0000.
- FETCH_PERF_EN defined, 5 pops then 2 redirects then rst: perf_fetched=5, perf_flushes=2, then both return to 0 after rst.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction-fetch front end.
//
// Issues one word read per cycle to a synchronous, 1-cycle-latency
// instruction memory. Each returned word is queued together with its PC.
// Decode takes the queue head through a valid/ready handshake. A redirect
// flushes the queue, drops any in-flight response and restarts fetch at the
// target address.
//
// Parameters:
//   QUEUE_DEPTH  instruction queue entries (power of two, >= 2)
//   RESET_PC     first fetch address after reset
//   IMEM_AW      word-address width presented to instruction memory
//
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   redirect       taken branch/jump from execute
//   redirect_pc    redirect target (bits [1:0] ignored)
//   imem_en        memory read request this cycle
//   imem_addr      word address of the request
//   imem_rdata     read data, valid the cycle after imem_en
//   out_valid      queue head valid
//   out_ready      decode accepts the head
//   out_pc         head PC
//   out_pcplus4    head PC + 4 (wraps at 2^32)
//   out_instr      head instruction word
//
// Optional build macro FETCH_PERF_EN adds:
//   perf_fetched   count of handshaked pops
//   perf_flushes   count of redirect cycles
module fetch_unit #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_AW     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pcplus4,
  output logic [31:0]        out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushes
`endif
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [PW+1:0] occupancy;
  logic          req;
  logic          enq;
  logic          pop;

  // Low target bits are forced to zero and never used.
  logic unused_bits;
  assign unused_bits = ^redirect_pc[1:0];

  always_comb begin
    // Reserve a slot for the in-flight response so an accepted response can
    // never overflow the queue.
    occupancy = {1'b0, count} + {{(PW + 1){1'b0}}, inflight};
    req       = !rst && !redirect && (occupancy < (PW + 2)'(QUEUE_DEPTH));
    enq       = inflight && !redirect;
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
  end

  assign imem_en   = req;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  always_comb begin
    out_pc      = '0;
    out_pcplus4 = '0;
    out_instr   = '0;
    if (out_valid) begin
      out_pc      = q_pc[head];
      out_pcplus4 = q_pc[head] + 32'd4;
      out_instr   = q_instr[head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      // Redirect overrides any concurrent pop or enqueue.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      // The previous response is always consumed this cycle, so inflight
      // simply tracks whether a new request went out.
      inflight <= req;
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; out_valid gates what is visible.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      q_pc[tail]    <= inflight_pc;
      q_instr[tail] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop)      perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned pops;
  int unsigned n_req;
  int unsigned pops_before;
  logic [31:0] exp_pc;

  fetch_unit #(
    .QUEUE_DEPTH(4),
    .RESET_PC(32'h0000_0100),
    .IMEM_AW(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_pcplus4(out_pcplus4),
    .out_instr(out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushes(perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-tagged instruction memory with 1-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= {4'hA, 16'h0000, imem_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: a handshake in the current cycle is checked against the
  // expected sequential stream, then time moves to just after the edge.
  task automatic cycle();
    if (out_valid && out_ready) begin
      check("head_pc", out_pc, exp_pc);
      check("head_pcplus4", out_pcplus4, exp_pc + 32'd4);
      check("head_instr", out_instr, {4'hA, 16'h0000, exp_pc[13:2]});
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0; pops = 0; n_req = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    exp_pc = 32'h100;
    @(posedge clk); #1;
    cycle();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_en", {31'd0, imem_en}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_pcplus4", out_pcplus4, 32'd0);
    check("rst_instr", out_instr, 32'd0);

    // Reset release latency and sequential streaming.
    rst = 1'b0; #1;
    check("t0_en", {31'd0, imem_en}, 32'd1);
    check("t0_addr", {20'd0, imem_addr}, 32'h040);
    cycle();
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_pc", out_pc, 32'h100);
    for (int i = 0; i < 6; i++) begin
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      cycle();
    end
    check("stream_next", exp_pc, 32'h118);

    // Back-pressure: exactly four entries, head stable, no extra requests.
    rst = 1'b1; out_ready = 1'b0;
    cycle();
    rst = 1'b0; #1;
    exp_pc = 32'h100; n_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_en) n_req++;
      if (out_valid) check("hold_pc", out_pc, 32'h100);
      cycle();
    end
    check("fill_reqs", n_req, 32'd4);
    check("full_en", {31'd0, imem_en}, 32'd0);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; #1;
    check("full_pop_en", {31'd0, imem_en}, 32'd0);
    cycle();
    check("resume_en", {31'd0, imem_en}, 32'd1);
    check("resume_addr", {20'd0, imem_addr}, 32'h044);
    for (int i = 0; i < 7; i++) begin
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      cycle();
    end
    check("drain_next", exp_pc, 32'h120);

    // Redirect to unaligned target with three queued and one in flight.
    rst = 1'b1; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("pre_redir_valid", {31'd0, out_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h2002; #1;
    check("redir_en", {31'd0, imem_en}, 32'd0);
    cycle();
    redirect = 1'b0; #1;
    check("redir_t1_valid", {31'd0, out_valid}, 32'd0);
    check("redir_t1_en", {31'd0, imem_en}, 32'd1);
    check("redir_t1_addr", {20'd0, imem_addr}, 32'h800);
    cycle();
    check("redir_t2_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("redir_t3_valid", {31'd0, out_valid}, 32'd1);
    check("redir_t3_pc", out_pc, 32'h2000);
    exp_pc = 32'h2000; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Redirect coinciding with a pop and an enqueue.
    check("steady_valid", {31'd0, out_valid}, 32'd1);
    check("steady_en", {31'd0, imem_en}, 32'd1);
    pops_before = pops;
    redirect = 1'b1; redirect_pc = 32'h3000;
    cycle();
    redirect = 1'b0; exp_pc = 32'h3000;
    check("redir_pop_once", pops - pops_before, 32'd1);
    check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("redir2_t2_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("redir2_t3_pc", out_pc, 32'h3000);
    for (int i = 0; i < 4; i++) cycle();

    // Back-to-back redirects: the second target wins.
    redirect = 1'b1; redirect_pc = 32'h4000;
    cycle();
    redirect_pc = 32'h5004;
    cycle();
    redirect = 1'b0; exp_pc = 32'h5004;
    cycle();
    cycle();
    check("b2b_pc", out_pc, 32'h5004);
    for (int i = 0; i < 3; i++) cycle();

    // 32-bit PC wrap.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0; exp_pc = 32'hFFFF_FFF8;
    cycle();
    cycle();
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    cycle();
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    check("wrap_pcplus4", out_pcplus4, 32'h0000_0000);
    cycle();
    check("wrap_pc2", out_pc, 32'h0000_0000);
    for (int i = 0; i < 3; i++) cycle();

`ifdef FETCH_PERF_EN
    rst = 1'b1; out_ready = 1'b0;
    cycle();
    check("perf_rst_fetched", perf_fetched, 32'd0);
    check("perf_rst_flushes", perf_flushes, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    exp_pc = 32'h100; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    cycle();
    redirect = 1'b0;
    check("perf_fetched", perf_fetched, 32'd5);
    check("perf_flushes", perf_flushes, 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("perf_clr_fetched", perf_fetched, 32'd0);
    check("perf_clr_flushes", perf_flushes, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
